// File: rtl/miner_pkg.sv
// Shared definitions for the miner host-link receive path.
//  WORK_BYTES    : bytes per work packet
//  MIDSTATE_BITS : midstate field, work_data[351:96]
//  DATA_BITS     : block-header tail field, work_data[95:0]
//  rx_state_t    : bit-level receiver FSM states
package miner_pkg;

   localparam int unsigned WORK_BYTES    = 44;
   localparam int unsigned MIDSTATE_BITS = 256;
   localparam int unsigned DATA_BITS     = 96;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver with 16x oversampling.
//  clk_in, reset_n : clock, async active-low reset
//  rx              : raw serial input (idle high)
//  byte_data       : last good byte
//  byte_valid      : 1-cycle pulse, byte_data is new
//  frame_err       : 1-cycle pulse, stop bit sampled low
//  busy            : high in START/DATA/STOP
//  tick            : oversample tick (1 clk every DIV clks)
//  start_det       : 1-cycle pulse on start-bit detect
module uart_rx_byte
   import miner_pkg::*;
#(
   parameter int unsigned DIV = 54
) (
   input  logic       clk_in,
   input  logic       reset_n,
   input  logic       rx,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       busy,
   output logic       tick,
   output logic       start_det
);

   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   rx_state_t        state, state_nx;
   logic             rx_meta, rx_sync;
   logic [DIV_W-1:0] div_cnt;
   logic [3:0]       tick_cnt;
   logic [2:0]       bit_idx;
   logic [1:0]       votes;
   logic [7:0]       shift;
   logic             armed;
   logic [3:0]       first_tick;
   logic             sample, decide, bit_end, maj;

   // Votes from the first two sample ticks are accumulated; the decision tick
   // adds its own live sample. START therefore resolves a glitch at tick 8.
   always_comb begin
      tick       = (div_cnt == DIV_W'(DIV - 1));
      first_tick = (state == RX_START) ? 4'd6 : 4'd7;
      sample     = tick && ((tick_cnt == first_tick) || (tick_cnt == first_tick + 4'd1));
      decide     = tick && (tick_cnt == first_tick + 4'd2);
      bit_end    = tick && (tick_cnt == 4'd15);
      maj        = ({1'b0, votes} + {2'b00, rx_sync}) >= 3'd2;
      start_det  = (state == RX_IDLE) && armed && !rx_sync;
      busy       = (state != RX_IDLE);
      state_nx   = state;
      case (state)
         RX_IDLE:  if (start_det) state_nx = RX_START;
         RX_START: if (decide && maj) state_nx = RX_IDLE;
                   else if (bit_end) state_nx = RX_DATA;
         RX_DATA:  if (bit_end && bit_idx == 3'd7) state_nx = RX_STOP;
         RX_STOP:  if (decide) state_nx = RX_IDLE;
         default:  state_nx = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         state      <= RX_IDLE;
         rx_meta    <= 1'b1;
         rx_sync    <= 1'b1;
         div_cnt    <= '0;
         tick_cnt   <= '0;
         bit_idx    <= '0;
         votes      <= '0;
         shift      <= '0;
         armed      <= 1'b1;
         byte_data  <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         rx_meta    <= rx;
         rx_sync    <= rx_meta;
         state      <= state_nx;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;

         if (start_det || tick) div_cnt <= '0;
         else                   div_cnt <= div_cnt + DIV_W'(1);

         if (start_det)  tick_cnt <= '0;
         else if (tick)  tick_cnt <= tick_cnt + 4'd1;

         if (start_det || bit_end) votes <= '0;
         else if (sample)          votes <= votes + {1'b0, rx_sync};

         if (start_det)                          bit_idx <= '0;
         else if (state == RX_DATA && bit_end)   bit_idx <= bit_idx + 3'd1;

         if (state == RX_DATA && decide) shift <= {maj, shift[7:1]};

         // A low stop bit disarms detection until the line is seen high,
         // so a held-low break yields a single frame_err.
         if (state == RX_STOP && decide) begin
            if (maj) begin
               byte_valid <= 1'b1;
               byte_data  <= shift;
            end else begin
               frame_err  <= 1'b1;
               armed      <= 1'b0;
            end
         end else if (state == RX_IDLE && rx_sync) begin
            armed <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/uart_work_rx.sv
// UART work-packet receiver: deframes 8N1 bytes and assembles 44-byte packets.
//  clk_in, reset_n : clock, async active-low reset (released synchronously)
//  rx              : serial input
//  byte_data/byte_valid/frame_err/busy : byte-level status
//  work_data       : last complete packet, first byte in MSBs
//  work_valid      : 1-cycle pulse, work_data updated
module uart_work_rx
   import miner_pkg::*;
#(
   parameter int unsigned CLK_HZ       = 100_000_000,
   parameter int unsigned BAUD         = 115200,
   parameter int unsigned OVERSAMPLE   = 16,
   parameter int unsigned WORK_BYTES   = miner_pkg::WORK_BYTES,
   parameter int unsigned TIMEOUT_BITS = 1000
) (
   input  logic                    clk_in,
   input  logic                    reset_n,
   input  logic                    rx,
   output logic [7:0]              byte_data,
   output logic                    byte_valid,
   output logic                    frame_err,
   output logic                    busy,
   output logic [8*WORK_BYTES-1:0] work_data,
   output logic                    work_valid
);

   localparam int unsigned DIV        = CLK_HZ / (BAUD * OVERSAMPLE);
   localparam int unsigned IDLE_LIMIT = OVERSAMPLE * TIMEOUT_BITS;
   localparam int unsigned IW         = $clog2(IDLE_LIMIT + 1);
   localparam int unsigned CW         = $clog2(WORK_BYTES + 1);
   localparam int unsigned WB         = 8 * WORK_BYTES;

   logic          rst_meta, rst_n;
   logic          tick, start_det, timeout;
   logic [CW-1:0] count, count_base;
   logic [IW-1:0] idle_cnt;
   logic [WB-9:0] shreg;
   logic [WB-1:0] shreg_nx;

   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         rst_meta <= 1'b0;
         rst_n    <= 1'b0;
      end else begin
         rst_meta <= 1'b1;
         rst_n    <= rst_meta;
      end
   end

   uart_rx_byte #(.DIV(DIV)) u_rx (
      .clk_in     (clk_in),
      .reset_n    (rst_n),
      .rx         (rx),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .frame_err  (frame_err),
      .busy       (busy),
      .tick       (tick),
      .start_det  (start_det)
   );

   // Timeout is applied before a coincident byte, which then starts a new packet.
   always_comb begin
      timeout    = (count != '0) && !busy && tick && (idle_cnt == IW'(IDLE_LIMIT - 1));
      count_base = timeout ? '0 : count;
      shreg_nx   = {shreg, byte_data};
   end

   always_ff @(posedge clk_in or negedge rst_n) begin
      if (!rst_n) begin
         count      <= '0;
         idle_cnt   <= '0;
         shreg      <= '0;
         work_data  <= '0;
         work_valid <= 1'b0;
      end else begin
         work_valid <= 1'b0;

         if (start_det || count == '0 || timeout) idle_cnt <= '0;
         else if (!busy && tick)                  idle_cnt <= idle_cnt + IW'(1);

         if (frame_err) begin
            count <= '0;
         end else if (byte_valid) begin
            shreg <= shreg_nx[WB-9:0];
            if (count_base == CW'(WORK_BYTES - 1)) begin
               count      <= '0;
               work_data  <= shreg_nx;
               work_valid <= 1'b1;
            end else begin
               count <= count_base + CW'(1);
            end
         end else if (timeout) begin
            count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_uart_work_rx.sv
`timescale 1ns/1ps
module tb_uart_work_rx;

   localparam int unsigned BAUD         = 115200;
   localparam int unsigned CLK_HZ       = 16 * BAUD * 4;
   localparam int unsigned TIMEOUT_BITS = 20;
   localparam int unsigned BIT_CLKS     = 64;

   logic         clk = 1'b0;
   logic         reset_n = 1'b0;
   logic         rx = 1'b1;
   logic [7:0]   byte_data;
   logic         byte_valid, frame_err, busy, work_valid;
   logic [351:0] work_data;

   uart_work_rx #(
      .CLK_HZ       (CLK_HZ),
      .BAUD         (BAUD),
      .OVERSAMPLE   (16),
      .WORK_BYTES   (44),
      .TIMEOUT_BITS (TIMEOUT_BITS)
   ) dut (
      .clk_in     (clk),
      .reset_n    (reset_n),
      .rx         (rx),
      .byte_data  (byte_data),
      .byte_valid (byte_valid),
      .frame_err  (frame_err),
      .busy       (busy),
      .work_data  (work_data),
      .work_valid (work_valid)
   );

   always #5 clk = ~clk;

   int unsigned  total = 0, passed = 0;
   int unsigned  obs_ferr = 0, obs_work = 0, exp_ferr = 0;
   logic         prev_bv = 1'b0;
   logic [7:0]   exp_bytes[$];
   logic [351:0] exp_work[$];
   logic [7:0]   mbytes[$];

   task automatic chk(input string name, input logic [351:0] act, input logic [351:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Reference packet model: a packet is simply the last 44 good bytes since
   // the last abort, first byte in the most significant position.
   task automatic model_byte(input logic [7:0] b);
      logic [351:0] w;
      mbytes.push_back(b);
      if (mbytes.size() == 44) begin
         w = '0;
         foreach (mbytes[i]) w = {w[343:0], mbytes[i]};
         exp_work.push_back(w);
         mbytes.delete();
      end
   endtask

   task automatic drive_bit(input logic v);
      rx = v;
      repeat (BIT_CLKS) @(negedge clk);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      if (stop) begin
         exp_bytes.push_back(b);
         model_byte(b);
      end else begin
         exp_ferr++;
         mbytes.delete();
      end
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop);
      rx = 1'b1;
   endtask

   task automatic send_random(input int unsigned n);
      for (int i = 0; i < int'(n); i++) begin
         send_byte(8'($urandom), 1'b1);
         repeat ($urandom_range(0, 4)) @(negedge clk);
      end
   endtask

   task automatic idle_bits(input int unsigned n);
      rx = 1'b1;
      repeat (n * BIT_CLKS) @(negedge clk);
      if (n > TIMEOUT_BITS) mbytes.delete();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_byte_data"},  byte_data,  8'h00);
      chk({tag, "_byte_valid"}, byte_valid, 1'b0);
      chk({tag, "_frame_err"},  frame_err,  1'b0);
      chk({tag, "_busy"},       busy,       1'b0);
      chk({tag, "_work_data"},  work_data,  '0);
      chk({tag, "_work_valid"}, work_valid, 1'b0);
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (byte_valid) begin
         if (exp_bytes.size() == 0) chk("byte_valid_unexpected", byte_valid, 1'b0);
         else chk("byte_data", byte_data, exp_bytes.pop_front());
      end
      if (frame_err) obs_ferr++;
      if (work_valid) begin
         obs_work++;
         chk("work_valid_timing", prev_bv, 1'b1);
         if (exp_work.size() == 0) chk("work_valid_unexpected", work_valid, 1'b0);
         else chk("work_data", work_data, exp_work.pop_front());
      end
      prev_bv = byte_valid;
   end

   initial begin
      repeat (200000) @(posedge clk);
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned w0, f0;
      logic [7:0]  b;

      repeat (5) @(negedge clk);
      chk_all_zero("reset");
      reset_n = 1'b1;
      repeat (10) @(negedge clk);

      // single byte
      send_byte(8'hA5, 1'b1);
      chk("t1_busy_after_stop", busy, 1'b0);
      chk("t1_frame_err_count", obs_ferr, 0);
      repeat (3) @(negedge clk);

      // bad stop bit aborts the partial packet, then a counting packet
      f0 = obs_ferr;
      send_byte(8'h3C, 1'b0);
      repeat (BIT_CLKS) @(negedge clk);
      chk("t4_frame_err_count", obs_ferr - f0, 1);
      w0 = obs_work;
      for (int i = 0; i < 44; i++) begin
         send_byte(8'(i), 1'b1);
         repeat (2) @(negedge clk);
      end
      chk("t2_work_count", obs_work - w0, 1);
      chk("t2_first_byte", work_data[351:344], 8'h00);
      chk("t2_last_byte", work_data[7:0], 8'h2B);

      // short glitch
      f0 = obs_ferr;
      rx = 1'b0;
      repeat (8) @(negedge clk);
      rx = 1'b1;
      repeat (3 * BIT_CLKS) @(negedge clk);
      chk("t3_busy_idle", busy, 1'b0);
      chk("t3_no_frame_err", obs_ferr - f0, 0);

      // break: one frame_err only
      f0 = obs_ferr;
      exp_ferr++;
      mbytes.delete();
      rx = 1'b0;
      repeat (15 * BIT_CLKS) @(negedge clk);
      chk("break_busy_idle", busy, 1'b0);
      rx = 1'b1;
      repeat (2 * BIT_CLKS) @(negedge clk);
      chk("break_frame_err_count", obs_ferr - f0, 1);

      // reset in the middle of byte 20
      send_random(19);
      b = 8'($urandom);
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(b[i]);
      rx = b[3];
      repeat (BIT_CLKS / 2) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk_all_zero("midreset");
      mbytes.delete();
      repeat (4) @(negedge clk);
      rx = 1'b1;
      reset_n = 1'b1;
      repeat (10) @(negedge clk);

      // partial packet discarded by idle timeout, then a full packet
      w0 = obs_work;
      send_random(10);
      idle_bits(25);
      send_random(44);
      chk("t5_work_count", obs_work - w0, 1);

      repeat (2 * BIT_CLKS) @(negedge clk);
      chk("frame_err_total", obs_ferr, exp_ferr);
      chk("byte_queue_drained", exp_bytes.size(), 0);
      chk("work_queue_drained", exp_work.size(), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
